// File: rtl/genius_sequence_controller.sv
// genius_sequence_controller: control unit for the memory game.
// Plays ROM patterns 0..rodada on the LEDs each round, then checks the
// player's button presses against the same ROM entries.
// Every output is driven from a register; nothing reaches an output
// combinationally from botoes.

module genius_sequence_controller #(
   parameter int SHOW_ON_CYCLES = 4,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int LAST_ROUND     = 15
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       iniciar,
   input  logic [3:0] botoes,
   output logic [3:0] rom_address,
   input  logic [3:0] rom_data,
   output logic [3:0] leds,
   output logic [3:0] rodada,
   output logic       pronto,
   output logic       acertou,
   output logic       errou,
   output logic       timeout
);

   localparam int ON_W  = (SHOW_ON_CYCLES > 1) ? $clog2(SHOW_ON_CYCLES) : 1;
   localparam int GAP_W = (GAP_CYCLES > 1)     ? $clog2(GAP_CYCLES)     : 1;
   localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [ON_W-1:0]  ON_LAST   = ON_W'(SHOW_ON_CYCLES - 1);
   localparam logic [ON_W-1:0]  ON_ONE    = ON_W'(1);
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);
   localparam logic [3:0]       ROUND_END = 4'(LAST_ROUND);

   typedef enum logic [2:0] {
      IDLE,
      SHOW_FETCH,
      SHOW_ON,
      SHOW_OFF,
      PLAY_WAIT,
      PLAY_CMP,
      WIN,
      LOSE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [3:0]       index;
   logic [3:0]       index_next;
   logic [3:0]       rodada_next;
   logic [ON_W-1:0]  on_timer;
   logic [ON_W-1:0]  on_timer_next;
   logic [GAP_W-1:0] gap_timer;
   logic [GAP_W-1:0] gap_timer_next;
   logic [TO_W-1:0]  timer;
   logic [TO_W-1:0]  timer_next;
   logic [3:0]       jogada;
   logic [3:0]       jogada_next;
   logic [3:0]       btn_prev;
   logic             timeout_cause;
   logic             timeout_cause_next;
   logic             press;

   // A press is the first cycle any button is down after all were released;
   // a button held from playback into the wait state never counts.
   assign press       = (botoes != 4'b0000) && (btn_prev == 4'b0000);
   assign rom_address = index;

   // State and datapath registers; reset aborts the game at once.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         index         <= 4'd0;
         rodada        <= 4'd0;
         on_timer      <= '0;
         gap_timer     <= '0;
         timer         <= '0;
         jogada        <= 4'd0;
         btn_prev      <= 4'd0;
         timeout_cause <= 1'b0;
      end else begin
         state         <= state_next;
         index         <= index_next;
         rodada        <= rodada_next;
         on_timer      <= on_timer_next;
         gap_timer     <= gap_timer_next;
         timer         <= timer_next;
         jogada        <= jogada_next;
         btn_prev      <= botoes;
         timeout_cause <= timeout_cause_next;
      end
   end

   // Next-state logic: playback pacing, press capture, compare and round advance.
   always_comb begin
      state_next         = state;
      index_next         = index;
      rodada_next        = rodada;
      on_timer_next      = on_timer;
      gap_timer_next     = gap_timer;
      timer_next         = timer;
      jogada_next        = jogada;
      timeout_cause_next = timeout_cause;

      case (state)
         IDLE, WIN, LOSE: begin
            if (iniciar) begin
               rodada_next        = 4'd0;
               index_next         = 4'd0;
               timeout_cause_next = 1'b0;
               state_next         = SHOW_FETCH;
            end
         end

         SHOW_FETCH: begin
            on_timer_next = '0;
            state_next    = SHOW_ON;
         end

         SHOW_ON: begin
            if (on_timer == ON_LAST) begin
               gap_timer_next = '0;
               state_next     = SHOW_OFF;
            end else begin
               on_timer_next = on_timer + ON_ONE;
            end
         end

         SHOW_OFF: begin
            if (gap_timer == GAP_LAST) begin
               if (index == rodada) begin
                  index_next = 4'd0;
                  timer_next = '0;
                  state_next = PLAY_WAIT;
               end else begin
                  index_next = index + 4'd1;
                  state_next = SHOW_FETCH;
               end
            end else begin
               gap_timer_next = gap_timer + GAP_ONE;
            end
         end

         PLAY_WAIT: begin
            timer_next = timer + TO_ONE;
            if (press) begin
               jogada_next = botoes;
               state_next  = PLAY_CMP;
            end else if (timer == TO_LAST) begin
               timeout_cause_next = 1'b1;
               state_next         = LOSE;
            end
         end

         PLAY_CMP: begin
            if (jogada != rom_data) begin
               state_next = LOSE;
            end else if (index < rodada) begin
               index_next = index + 4'd1;
               timer_next = '0;
               state_next = PLAY_WAIT;
            end else if (rodada == ROUND_END) begin
               state_next = WIN;
            end else begin
               rodada_next = rodada + 4'd1;
               index_next  = 4'd0;
               state_next  = SHOW_FETCH;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   // Output register stage: LEDs show ROM data only while lit, all-on after a win.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         leds    <= 4'b0000;
         pronto  <= 1'b0;
         acertou <= 1'b0;
         errou   <= 1'b0;
         timeout <= 1'b0;
      end else begin
         if (state == SHOW_ON) begin
            leds <= rom_data;
         end else if (state == WIN) begin
            leds <= 4'b1111;
         end else begin
            leds <= 4'b0000;
         end
         pronto  <= (state == WIN) || (state == LOSE);
         acertou <= (state == WIN);
         errou   <= (state == LOSE);
         timeout <= (state == LOSE) && timeout_cause;
      end
   end

endmodule

// File: tb/tb_genius_sequence_controller.sv
// Testbench for genius_sequence_controller with a 3-round game (LAST_ROUND=2)
// and a small synchronous pattern ROM beside the DUT.

module tb_genius_sequence_controller;

   logic       clock   = 1'b0;
   logic       reset_n = 1'b0;
   logic       iniciar = 1'b0;
   logic [3:0] botoes  = 4'b0000;
   logic [3:0] rom_address;
   logic [3:0] rom_data;
   logic [3:0] leds;
   logic [3:0] rodada;
   logic       pronto;
   logic       acertou;
   logic       errou;
   logic       timeout;

   int total = 0;
   int bad   = 0;

   genius_sequence_controller #(
      .SHOW_ON_CYCLES(4),
      .GAP_CYCLES(2),
      .TIMEOUT_CYCLES(64),
      .LAST_ROUND(2)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .iniciar(iniciar),
      .botoes(botoes),
      .rom_address(rom_address),
      .rom_data(rom_data),
      .leds(leds),
      .rodada(rodada),
      .pronto(pronto),
      .acertou(acertou),
      .errou(errou),
      .timeout(timeout)
   );

   // 10-unit clock period.
   always #5 clock = ~clock;

   // Pattern ROM with one cycle of read latency.
   always @(posedge clock) begin
      case (rom_address)
         4'd0:    rom_data <= 4'b1000;
         4'd1:    rom_data <= 4'b0100;
         4'd2:    rom_data <= 4'b0010;
         default: rom_data <= 4'b0001;
      endcase
   end

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", tag, observed, expected, $time);
      end
   endtask

   // Advance one clock; return at the following falling edge.
   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   // Press a button pattern for one cycle, then release it.
   task automatic applyStimulus(input logic [3:0] b);
      botoes = b;
      tick();
      botoes = 4'b0000;
      tick();
   endtask

   // One-cycle start request.
   task automatic startGame();
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
   endtask

   // Called right after the edge that enters SHOW_FETCH: one dark cycle,
   // four lit cycles with the pattern, then two dark gap cycles.
   task automatic showPattern(input logic [3:0] pat);
      tick();
      checkOutput("fetch_dark", leds, 4'b0000);
      repeat (4) begin
         tick();
         checkOutput("show_on", leds, pat);
      end
      repeat (2) begin
         tick();
         checkOutput("show_gap", leds, 4'b0000);
      end
   endtask

   // Safety bound so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset state
      reset_n = 1'b0;
      repeat (2) tick();
      checkOutput("rst_leds", leds, 4'b0000);
      checkOutput("rst_rodada", rodada, 4'b0000);
      checkOutput("rst_addr", rom_address, 4'b0000);
      checkOutput("rst_pronto", 4'(pronto), 4'b0000);
      checkOutput("rst_acertou", 4'(acertou), 4'b0000);
      checkOutput("rst_errou", 4'(errou), 4'b0000);
      checkOutput("rst_timeout", 4'(timeout), 4'b0000);
      reset_n = 1'b1;
      repeat (2) tick();
      checkOutput("idle_leds", leds, 4'b0000);

      // Full winning game
      $display("[TB] winning game");
      startGame();
      checkOutput("r0_rodada", rodada, 4'd0);
      showPattern(4'b1000);
      applyStimulus(4'b1000);
      checkOutput("r1_rodada", rodada, 4'd1);
      showPattern(4'b1000);
      showPattern(4'b0100);
      applyStimulus(4'b1000);
      checkOutput("r1_addr", rom_address, 4'd1);
      checkOutput("r1_mid_rodada", rodada, 4'd1);
      applyStimulus(4'b0100);
      checkOutput("r2_rodada", rodada, 4'd2);
      showPattern(4'b1000);
      showPattern(4'b0100);
      showPattern(4'b0010);
      applyStimulus(4'b1000);
      applyStimulus(4'b0100);
      applyStimulus(4'b0010);
      checkOutput("win_lag_pronto", 4'(pronto), 4'b0000);
      tick();
      checkOutput("win_pronto", 4'(pronto), 4'b0001);
      checkOutput("win_acertou", 4'(acertou), 4'b0001);
      checkOutput("win_errou", 4'(errou), 4'b0000);
      checkOutput("win_timeout", 4'(timeout), 4'b0000);
      checkOutput("win_leds", leds, 4'b1111);
      tick();
      checkOutput("win_hold_leds", leds, 4'b1111);

      // Wrong press in round 1
      $display("[TB] wrong press");
      startGame();
      showPattern(4'b1000);
      checkOutput("restart_pronto", 4'(pronto), 4'b0000);
      checkOutput("restart_acertou", 4'(acertou), 4'b0000);
      checkOutput("restart_rodada", rodada, 4'd0);
      applyStimulus(4'b1000);
      checkOutput("wr_r1_rodada", rodada, 4'd1);
      showPattern(4'b1000);
      showPattern(4'b0100);
      applyStimulus(4'b1000);
      applyStimulus(4'b0010);
      checkOutput("wr_lag_errou", 4'(errou), 4'b0000);
      tick();
      checkOutput("wr_errou", 4'(errou), 4'b0001);
      checkOutput("wr_pronto", 4'(pronto), 4'b0001);
      checkOutput("wr_acertou", 4'(acertou), 4'b0000);
      checkOutput("wr_timeout", 4'(timeout), 4'b0000);
      checkOutput("wr_leds", leds, 4'b0000);

      // Timeout with no press
      $display("[TB] timeout");
      startGame();
      showPattern(4'b1000);
      checkOutput("to_clear_errou", 4'(errou), 4'b0000);
      checkOutput("to_clear_pronto", 4'(pronto), 4'b0000);
      repeat (64) tick();
      checkOutput("to_early_errou", 4'(errou), 4'b0000);
      tick();
      checkOutput("to_errou", 4'(errou), 4'b0001);
      checkOutput("to_timeout", 4'(timeout), 4'b0001);
      checkOutput("to_pronto", 4'(pronto), 4'b0001);

      // Held button is not a press; multi-bit press loses
      $display("[TB] held and multi-bit presses");
      botoes = 4'b1000;
      startGame();
      showPattern(4'b1000);
      checkOutput("held_timeout_clr", 4'(timeout), 4'b0000);
      checkOutput("held_errou_clr", 4'(errou), 4'b0000);
      repeat (3) tick();
      checkOutput("held_rodada", rodada, 4'd0);
      checkOutput("held_errou", 4'(errou), 4'b0000);
      botoes = 4'b0000;
      tick();
      applyStimulus(4'b1000);
      checkOutput("held_accept_rodada", rodada, 4'd1);
      showPattern(4'b1000);
      showPattern(4'b0100);
      applyStimulus(4'b1100);
      tick();
      checkOutput("multi_errou", 4'(errou), 4'b0001);
      checkOutput("multi_timeout", 4'(timeout), 4'b0000);

      // Asynchronous reset during playback
      $display("[TB] reset mid-playback");
      startGame();
      showPattern(4'b1000);
      applyStimulus(4'b1000);
      tick();
      tick();
      checkOutput("pre_reset_leds", leds, 4'b1000);
      checkOutput("pre_reset_rodada", rodada, 4'd1);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async_leds", leds, 4'b0000);
      checkOutput("async_rodada", rodada, 4'd0);
      checkOutput("async_pronto", 4'(pronto), 4'b0000);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (3) tick();
      checkOutput("post_reset_leds", leds, 4'b0000);
      checkOutput("post_reset_rodada", rodada, 4'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
